twotoone_mux_arbiter: RTL and testbench



---
 rtl/twotoone_mux_arbiter.sv | 119 +++++++++++
 tb/tb_twotoone_mux_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twotoone_mux_arbiter.sv
// Round-robin packet arbiter for two valid/ready requesters feeding one downstream port.
// Grant is held for a whole packet; the mux select S and priority are registered.
module twotoone_mux_arbiter #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   input  logic [DW-1:0] a_data,
   input  logic          a_last,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [DW-1:0] b_data,
   input  logic          b_last,
   output logic          b_ready,
   output logic          z_valid,
   output logic [DW-1:0] z_data,
   output logic          z_last,
   input  logic          z_ready,
   output logic          S,
   output logic          busy
);

   typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

   state_e state_q, state_d;
   logic   s_q, s_d;
   logic   prio_q, prio_d;
   // Set once a beat of the current packet has transferred; a grant that sees no
   // beat yet may be released, a packet in progress must wait for its requester.
   logic   open_q, open_d;

   function automatic state_e arb(input logic av, input logic bv, input logic pr);
      if (av && (!bv || !pr)) begin
         return StGntA;
      end else if (bv) begin
         return StGntB;
      end else begin
         return StIdle;
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         s_q     <= 1'b0;
         prio_q  <= 1'b0;
         open_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         prio_q  <= prio_d;
         open_q  <= open_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      prio_d  = prio_q;
      open_d  = open_q;
      z_valid = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
      z_data  = s_q ? b_data : a_data;
      z_last  = s_q ? b_last : a_last;

      unique case (state_q)
         StIdle: begin
            open_d  = 1'b0;
            state_d = arb(a_valid, b_valid, prio_q);
         end
         StGntA: begin
            z_valid = a_valid;
            a_ready = z_ready;
            if (a_valid && z_ready) begin
               if (a_last) begin
                  prio_d  = 1'b1;
                  open_d  = 1'b0;
                  state_d = arb(a_valid, b_valid, 1'b1);
               end else begin
                  open_d = 1'b1;
               end
            end else if (!a_valid && !open_q) begin
               state_d = arb(a_valid, b_valid, prio_q);
            end
         end
         StGntB: begin
            z_valid = b_valid;
            b_ready = z_ready;
            if (b_valid && z_ready) begin
               if (b_last) begin
                  prio_d  = 1'b0;
                  open_d  = 1'b0;
                  state_d = arb(a_valid, b_valid, 1'b0);
               end else begin
                  open_d = 1'b1;
               end
            end else if (!b_valid && !open_q) begin
               state_d = arb(a_valid, b_valid, prio_q);
            end
         end
         default: begin
            state_d = StIdle;
            open_d  = 1'b0;
         end
      endcase

      if (state_d == StGntA) begin
         s_d = 1'b0;
      end else if (state_d == StGntB) begin
         s_d = 1'b1;
      end
   end

   assign S    = s_q;
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_twotoone_mux_arbiter.sv
// Directed bench for twotoone_mux_arbiter: single requester, contention, backpressure,
// no pre-emption, re-grant and asynchronous reset mid-packet.
module tb_twotoone_mux_arbiter;

   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst_n;
   logic          a_valid, b_valid;
   logic [DW-1:0] a_data, b_data;
   logic          a_last, b_last;
   logic          a_ready, b_ready;
   logic          z_valid;
   logic [DW-1:0] z_data;
   logic          z_last;
   logic          z_ready;
   logic          S;
   logic          busy;

   int errors = 0;
   int checks = 0;

   twotoone_mux_arbiter #(.DW(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_valid (a_valid),
      .a_data  (a_data),
      .a_last  (a_last),
      .a_ready (a_ready),
      .b_valid (b_valid),
      .b_data  (b_data),
      .b_last  (b_last),
      .b_ready (b_ready),
      .z_valid (z_valid),
      .z_data  (z_data),
      .z_last  (z_last),
      .z_ready (z_ready),
      .S       (S),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      b_valid = 1'b0; b_data = '0; b_last = 1'b0;
      z_ready = 1'b1;
      #12;
      chk("rst_z_valid", z_valid, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_S", S, 0);
      rst_n = 1'b1;
      tick();

      // Single requester A, 3 beats
      a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
      settle();
      chk("t1_idle_z_valid", z_valid, 0);
      chk("t1_idle_a_ready", a_ready, 0);
      tick();
      settle();
      chk("t1_grant_S", S, 0);
      chk("t1_grant_busy", busy, 1);
      chk("t1_b0_z_valid", z_valid, 1);
      chk("t1_b0_z_data", z_data, 8'h11);
      chk("t1_b0_a_ready", a_ready, 1);
      chk("t1_b0_b_ready", b_ready, 0);
      tick();
      a_data = 8'h22;
      settle();
      chk("t1_b1_z_data", z_data, 8'h22);
      chk("t1_b1_b_ready", b_ready, 0);
      tick();
      a_data = 8'h33; a_last = 1'b1;
      settle();
      chk("t1_b2_z_data", z_data, 8'h33);
      chk("t1_b2_z_last", z_last, 1);
      chk("t1_b2_b_ready", b_ready, 0);
      tick();
      a_valid = 1'b0; a_last = 1'b0;
      settle();
      chk("t1_post_z_valid", z_valid, 0);
      chk("t1_post_b_ready", b_ready, 0);
      tick();
      settle();
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_S", S, 0);

      // Re-grant: two back-to-back single-beat packets from A
      a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
      tick();
      settle();
      chk("rg_p0_z_valid", z_valid, 1);
      chk("rg_p0_z_data", z_data, 8'hA1);
      tick();
      a_data = 8'hA2;
      settle();
      chk("rg_p1_z_valid", z_valid, 1);
      chk("rg_p1_z_data", z_data, 8'hA2);
      chk("rg_p1_busy", busy, 1);
      tick();
      a_valid = 1'b0; a_last = 1'b0;
      tick();
      settle();
      chk("rg_idle_busy", busy, 0);

      // Contention from reset: alternating 2-beat packets A,B,A,B
      rst_n = 1'b0;
      settle();
      chk("ct_rst_busy", busy, 0);
      rst_n = 1'b1;
      a_valid = 1'b1; a_data = 8'hA0; a_last = 1'b0;
      b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b0;
      tick();
      settle();
      chk("ct_a0_S", S, 0);
      chk("ct_a0_z_data", z_data, 8'hA0);
      chk("ct_a0_b_ready", b_ready, 0);
      tick();
      a_data = 8'hA1; a_last = 1'b1;
      settle();
      chk("ct_a1_z_data", z_data, 8'hA1);
      chk("ct_a1_S", S, 0);
      tick();
      a_data = 8'hA2; a_last = 1'b0;
      settle();
      chk("ct_b0_S", S, 1);
      chk("ct_b0_z_valid", z_valid, 1);
      chk("ct_b0_z_data", z_data, 8'hB0);
      chk("ct_b0_a_ready", a_ready, 0);
      tick();
      b_data = 8'hB1; b_last = 1'b1;
      settle();
      chk("ct_b1_z_data", z_data, 8'hB1);
      tick();
      b_data = 8'hB2; b_last = 1'b0;
      settle();
      chk("ct_a2_S", S, 0);
      chk("ct_a2_z_data", z_data, 8'hA2);
      tick();
      a_data = 8'hA3; a_last = 1'b1;
      settle();
      chk("ct_a3_z_data", z_data, 8'hA3);
      tick();
      a_valid = 1'b0; a_last = 1'b0;
      settle();
      chk("ct_b2_S", S, 1);
      chk("ct_b2_z_data", z_data, 8'hB2);
      tick();
      b_data = 8'hB3; b_last = 1'b1;
      settle();
      chk("ct_b3_z_data", z_data, 8'hB3);
      tick();
      b_valid = 1'b0; b_last = 1'b0;
      tick();
      settle();
      chk("ct_idle_busy", busy, 0);

      // Backpressure on B mid-packet
      b_valid = 1'b1; b_data = 8'hC0; b_last = 1'b0;
      tick();
      settle();
      chk("bp_grant_S", S, 1);
      chk("bp_c0_z_data", z_data, 8'hC0);
      tick();
      b_data = 8'hC1; z_ready = 1'b0;
      settle();
      for (int i = 0; i < 4; i++) begin
         chk("bp_hold_b_ready", b_ready, 0);
         chk("bp_hold_z_data", z_data, 8'hC1);
         chk("bp_hold_busy", busy, 1);
         chk("bp_hold_S", S, 1);
         tick();
      end
      z_ready = 1'b1;
      settle();
      chk("bp_rel_b_ready", b_ready, 1);
      chk("bp_rel_z_data", z_data, 8'hC1);
      tick();
      b_data = 8'hC2; b_last = 1'b1;
      settle();
      chk("bp_c2_z_data", z_data, 8'hC2);
      chk("bp_c2_z_last", z_last, 1);
      tick();
      b_valid = 1'b0; b_last = 1'b0;
      tick();
      settle();
      chk("bp_idle_busy", busy, 0);

      // No pre-emption: B requests during beat 2 of a 5-beat A packet
      a_valid = 1'b1; a_data = 8'hD0; a_last = 1'b0;
      tick();
      settle();
      chk("np_grant_S", S, 0);
      tick();
      a_data = 8'hD1;
      b_valid = 1'b1; b_data = 8'hE0; b_last = 1'b1;
      settle();
      chk("np_d1_z_data", z_data, 8'hD1);
      chk("np_d1_b_ready", b_ready, 0);
      for (int i = 2; i < 4; i++) begin
         tick();
         a_data = 8'hD0 + 8'(i);
         settle();
         chk("np_mid_S", S, 0);
         chk("np_mid_b_ready", b_ready, 0);
         chk("np_mid_z_data", z_data, 8'hD0 + 32'(i));
      end
      tick();
      a_data = 8'hD4; a_last = 1'b1;
      settle();
      chk("np_d4_S", S, 0);
      chk("np_d4_z_last", z_last, 1);
      tick();
      a_valid = 1'b0; a_last = 1'b0;
      settle();
      chk("np_b_S", S, 1);
      chk("np_b_z_data", z_data, 8'hE0);
      chk("np_b_a_ready", a_ready, 0);
      tick();
      b_valid = 1'b0; b_last = 1'b0;
      tick();
      settle();
      chk("np_idle_busy", busy, 0);

      // Asynchronous reset during beat 2 of an A packet; B waits but A wins after release
      a_valid = 1'b1; a_data = 8'hF0; a_last = 1'b0;
      tick();
      tick();
      a_data = 8'hF1;
      settle();
      chk("rs_pre_busy", busy, 1);
      chk("rs_pre_z_data", z_data, 8'hF1);
      rst_n = 1'b0;
      settle();
      chk("rs_z_valid", z_valid, 0);
      chk("rs_a_ready", a_ready, 0);
      chk("rs_busy", busy, 0);
      chk("rs_S", S, 0);
      a_data = 8'hF0;
      b_valid = 1'b1; b_data = 8'h5B; b_last = 1'b1;
      settle();
      rst_n = 1'b1;
      tick();
      settle();
      chk("rs_after_S", S, 0);
      chk("rs_after_busy", busy, 1);
      chk("rs_after_z_data", z_data, 8'hF0);
      chk("rs_after_b_ready", b_ready, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
